// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - coin slot synchronizer, debouncer, 2-deep coin buffer with credit and refund
// Optional COIN_TIMEOUT_EN: flush and refund the buffer when the head coin waits TIMEOUT_CYCLES for ack.
module coin_acceptor #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CREDIT_W        = 5,
   parameter int TIMEOUT_CYCLES  = 200
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                s_cinco,
   input  logic                s_diez,
   input  logic                ack,
   input  logic                cancel,
   output logic                hm,
   output logic                mc,
   output logic                md,
   output logic [CREDIT_W-1:0] credit,
   output logic                rechazo,
   output logic [CREDIT_W-1:0] refund,
   output logic                refund_v
);

   localparam logic [3:0]          DB_MAX  = 4'(DEBOUNCE_CYCLES);
   localparam logic [3:0]          DB_LAST = 4'(DEBOUNCE_CYCLES - 1);
   localparam logic [CREDIT_W-1:0] VAL_5   = CREDIT_W'(5);
   localparam logic [CREDIT_W-1:0] VAL_10  = CREDIT_W'(10);

   // bit 0 tracks the 5-cent slot, bit 1 the 10-cent slot
   logic [1:0] sync1, sync2, armed, rec;
   logic [3:0] db_cnt [2];

   logic [1:0]          slot, slot_n;
   logic [1:0]          count, count_n;
   logic [CREDIT_W-1:0] credit_n, refund_n, mid_credit;
   logic                refund_v_n, rechazo_n;
   logic                empty, full, pop, push, one_rec, reject, flush, coin_type;
   logic                timeout_fire;

   function automatic logic [CREDIT_W-1:0] coin_val(input logic t);
      return t ? VAL_10 : VAL_5;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= {s_diez, s_cinco};
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         armed     <= '0;
         db_cnt[0] <= '0;
         db_cnt[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (!sync2[i]) begin
               db_cnt[i] <= '0;
               armed[i]  <= 1'b1;
            end else begin
               if (db_cnt[i] != DB_MAX)
                  db_cnt[i] <= db_cnt[i] + 4'd1;
               if (rec[i])
                  armed[i] <= 1'b0;
            end
         end
      end
   end

   // recognition fires on the edge where the count steps onto DEBOUNCE_CYCLES
   always_comb begin
      rec = '0;
      for (int i = 0; i < 2; i++)
         rec[i] = sync2[i] && armed[i] && (db_cnt[i] == DB_LAST);
   end

   assign empty     = (count == 2'd0);
   assign full      = (count == 2'd2);
   assign one_rec   = rec[0] ^ rec[1];
   assign coin_type = rec[1];
   assign pop       = ack && !empty;
   assign push      = one_rec && (!full || pop);
   assign reject    = (&rec) || (one_rec && full && !pop);
   assign flush     = cancel || timeout_fire;

`ifdef COIN_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt;

   assign timeout_fire = !empty && !ack && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         to_cnt <= '0;
      else if (empty || ack || cancel || timeout_fire)
         to_cnt <= '0;
      else
         to_cnt <= to_cnt + TO_W'(1);
   end
`else
   assign timeout_fire = 1'b0;
`endif

   // pop first, then push, then flush; refund sees the post-pop/push credit
   always_comb begin
      slot_n     = slot;
      count_n    = count;
      mid_credit = credit;
      credit_n   = credit;
      refund_n   = '0;
      refund_v_n = 1'b0;
      rechazo_n  = reject;
      if (pop) begin
         slot_n     = {1'b0, slot[1]};
         count_n    = count - 2'd1;
         mid_credit = mid_credit - coin_val(slot[0]);
      end
      if (push) begin
         if (count_n == 2'd0)
            slot_n[0] = coin_type;
         else
            slot_n[1] = coin_type;
         count_n    = count_n + 2'd1;
         mid_credit = mid_credit + coin_val(coin_type);
      end
      credit_n = mid_credit;
      if (flush) begin
         slot_n     = '0;
         count_n    = '0;
         credit_n   = '0;
         refund_n   = mid_credit;
         refund_v_n = (mid_credit != '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot     <= '0;
         count    <= '0;
         credit   <= '0;
         refund   <= '0;
         refund_v <= 1'b0;
         rechazo  <= 1'b0;
      end else begin
         slot     <= slot_n;
         count    <= count_n;
         credit   <= credit_n;
         refund   <= refund_n;
         refund_v <= refund_v_n;
         rechazo  <= rechazo_n;
      end
   end

   assign hm = !empty;
   assign mc = hm && !slot[0];
   assign md = hm && slot[0];

endmodule
